// File: rtl/atm_pkg.sv
// Shared definitions for the ATM entry sequencer: state encoding, action codes,
// boolean constants and the account-number limit.
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_ENTRY,
    S_FIND_WAIT,
    S_PIN_ENTRY,
    S_AUTH_WAIT,
    S_SESSION,
    S_LOCKED
  } state_t;

  localparam logic ACT_FIND = 1'b0;
  localparam logic ACT_AUTH = 1'b1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int         ACC_W          = 14;
  localparam logic [13:0] ACC_LIMIT     = 14'd4095;
  localparam logic [2:0]  ACC_MAX_DIGITS = 3'd4;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_dec_accumulator.sv
// Decimal account-number accumulator: shift-multiply-add of BCD digits with a
// four-digit saturating count and an over-limit flag.
module atm_dec_accumulator
  import atm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        add,
  input  logic [3:0]  digit,
  output logic [11:0] acc_num,
  output logic        overflow
);

  logic [ACC_W-1:0] acc;
  logic [2:0]       count;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {10'd0, digit};
      count <= 3'd1;
    end else if (add && (count < ACC_MAX_DIGITS)) begin
      // Four digits max 9999, so the 14-bit product never wraps.
      acc   <= acc * 14'd10 + {10'd0, digit};
      count <= count + 3'd1;
    end
  end

  assign acc_num  = acc[11:0];
  assign overflow = acc > ACC_LIMIT;

endmodule

// File: rtl/atm_entry_sequencer.sv
// ATM keypad entry sequencer: account/PIN collection, retry lockout, session
// control. Optional inactivity timeout enabled by defining ATM_ENTRY_TIMEOUT_EN.
module atm_entry_sequencer
  import atm_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 1000
`ifdef ATM_ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 5000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        cancel,
  input  logic        logout,
  input  logic        wasSuccessful,
  input  logic [3:0]  accIndex,
  output logic [11:0] accNumber,
  output logic [3:0]  pin,
  output logic        action,
  output logic        deAuth,
  output logic        session_active,
  output logic [3:0]  session_index,
  output logic        locked,
  output logic        err_pulse,
  output logic [2:0]  attempts_left
);

  localparam int         LOCK_W        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [2:0] ATTEMPTS_INIT = 3'(MAX_ATTEMPTS);

  state_t            state;
  logic [LOCK_W-1:0] lock_cnt;
  logic              pin_held;
  logic [3:0]        pin_cand;
  logic [11:0]       acc_num;
  logic              overflow;
  logic              timeout_hit;

  logic enter_key, digit_key;
  logic abort, acc_over, find_fail, entry_timeout, sess_end, lock_done;
  logic acc_clear, clear_out;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    enter_key     = FALSE;
    digit_key     = FALSE;
    abort         = FALSE;
    acc_over      = FALSE;
    find_fail     = FALSE;
    entry_timeout = FALSE;
    sess_end      = FALSE;
    lock_done     = FALSE;

    // cancel > enter > digit; lower-priority strobes in the same cycle are dropped.
    enter_key = !cancel && enter;
    digit_key = !cancel && !enter && digit_valid && is_bcd(digit);

    abort         = cancel && (state inside {S_ACC_ENTRY, S_FIND_WAIT, S_PIN_ENTRY, S_AUTH_WAIT});
    acc_over      = (state == S_ACC_ENTRY) && enter_key && overflow;
    find_fail     = (state == S_FIND_WAIT) && !cancel && !wasSuccessful;
    entry_timeout = timeout_hit && (state inside {S_ACC_ENTRY, S_PIN_ENTRY});
    sess_end      = (state == S_SESSION) && (logout || cancel || timeout_hit);
    lock_done     = (state == S_LOCKED) && (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
  end

  assign acc_clear = abort || acc_over || find_fail || entry_timeout;
  assign clear_out = acc_clear || sess_end || lock_done;

  atm_dec_accumulator u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .load     ((state == S_IDLE) && digit_key),
    .add      ((state == S_ACC_ENTRY) && digit_key),
    .digit    (digit),
    .acc_num  (acc_num),
    .overflow (overflow)
  );

`ifdef ATM_ENTRY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            counting;
  logic            any_key;

  assign counting    = state inside {S_ACC_ENTRY, S_PIN_ENTRY, S_SESSION};
  assign any_key     = cancel || enter || digit_key || logout;
  assign timeout_hit = counting && !any_key && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !counting || any_key) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = FALSE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      accNumber      <= '0;
      pin            <= '0;
      action         <= ACT_FIND;
      deAuth         <= FALSE;
      session_active <= FALSE;
      session_index  <= '0;
      locked         <= FALSE;
      err_pulse      <= FALSE;
      attempts_left  <= ATTEMPTS_INIT;
      lock_cnt       <= '0;
      pin_held       <= FALSE;
      pin_cand       <= '0;
    end else begin
      deAuth    <= FALSE;
      err_pulse <= FALSE;

      case (state)
        S_IDLE: if (digit_key) state <= S_ACC_ENTRY;

        S_ACC_ENTRY: begin
          if (cancel) state <= S_IDLE;
          else if (timeout_hit) begin
            err_pulse <= TRUE;
            state     <= S_IDLE;
          end else if (enter_key) begin
            if (overflow) err_pulse <= TRUE;
            else begin
              accNumber <= acc_num;
              action    <= ACT_FIND;
              state     <= S_FIND_WAIT;
            end
          end
        end

        S_FIND_WAIT: begin
          if (cancel) state <= S_IDLE;
          else if (wasSuccessful) begin
            attempts_left <= ATTEMPTS_INIT;
            pin_held      <= FALSE;
            state         <= S_PIN_ENTRY;
          end else begin
            err_pulse <= TRUE;
            state     <= S_ACC_ENTRY;
          end
        end

        S_PIN_ENTRY: begin
          if (cancel) state <= S_IDLE;
          else if (timeout_hit) begin
            err_pulse <= TRUE;
            state     <= S_IDLE;
          end else if (enter_key && pin_held) begin
            pin    <= pin_cand;
            action <= ACT_AUTH;
            state  <= S_AUTH_WAIT;
          end else if (digit_key && !pin_held) begin
            pin_held <= TRUE;
            pin_cand <= digit;
          end
        end

        S_AUTH_WAIT: begin
          if (cancel) state <= S_IDLE;
          else if (wasSuccessful) begin
            session_index  <= accIndex;
            session_active <= TRUE;
            state          <= S_SESSION;
          end else begin
            err_pulse     <= TRUE;
            attempts_left <= attempts_left - 3'd1;
            pin_held      <= FALSE;
            if (attempts_left <= 3'd1) begin
              locked   <= TRUE;
              lock_cnt <= '0;
              state    <= S_LOCKED;
            end else begin
              state <= S_PIN_ENTRY;
            end
          end
        end

        S_SESSION: begin
          if (sess_end) begin
            deAuth         <= TRUE;
            session_active <= FALSE;
            session_index  <= '0;
            state          <= S_IDLE;
          end
        end

        S_LOCKED: begin
          if (lock_done) begin
            locked        <= FALSE;
            attempts_left <= ATTEMPTS_INIT;
            state         <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Later assignment wins: any clearing event zeroes the authentication outputs.
      if (clear_out) begin
        accNumber <= '0;
        pin       <= '0;
        action    <= ACT_FIND;
      end
    end
  end

endmodule

// File: doc/atm_entry_sequencer.md
# atm_entry_sequencer

Keypad front-end for the ATM authentication stage. It collects a decimal account number and a single-digit PIN from the keypad. It drives `accNumber`/`pin`/`action` into the combinational authentication block and samples `wasSuccessful`/`accIndex`. On success it opens a session for the downstream menu controller. It also owns the retry-attempt lockout and the `deAuth` pulse.

## Interface
- `MAX_ATTEMPTS`, 3: wrong-PIN attempts allowed before lockout (1..7).
- `LOCK_CYCLES`, 1000: cycles spent in LOCKED.
- `TIMEOUT_CYCLES`, 5000: inactivity limit in entry states (only with timeout macro).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `digit_valid` in 1: keypad digit strobe, one cycle per key.
- `digit` in 4: BCD key value; 10..15 ignored.
- `enter` in 1: enter key strobe.
- `cancel` in 1: cancel key strobe.
- `logout` in 1: end-session request.
- `wasSuccessful` in 1: authentication result.
- `accIndex` in 4: matched database index.
- `accNumber` out 12: registered account number to authentication.
- `pin` out 4: registered PIN to authentication.
- `action` out 1: 0 = FIND, 1 = AUTHENTICATE.
- `deAuth` out 1: one-cycle pulse on session end.
- `session_active` out 1: high while a session is open.
- `session_index` out 4: `accIndex` latched at authentication.
- `locked` out 1: high in LOCKED.
- `err_pulse` out 1: one-cycle pulse on any rejected entry.
- `attempts_left` out 3: remaining PIN attempts.

## Operation
- States: IDLE, ACC_ENTRY, FIND_WAIT, PIN_ENTRY, AUTH_WAIT, SESSION, LOCKED.
- Key priority per cycle: `cancel` > `enter` > `digit_valid`. Lower-priority strobes in the same cycle are dropped.
- IDLE: a valid digit loads the accumulator with that digit, sets count = 1, and moves to ACC_ENTRY.
- ACC_ENTRY digit: acc = acc*10 + digit, using a 14-bit accumulator. The count saturates at 4; a 5th or later digit is ignored.
- ACC_ENTRY `enter`:
  - If acc > 4095: `err_pulse`, clear, stay in ACC_ENTRY.
  - Otherwise: `accNumber` = acc[11:0], `action` = FIND, go to FIND_WAIT.
- FIND_WAIT, one cycle, sample `wasSuccessful`:
  - 1: go to PIN_ENTRY, `attempts_left` = MAX_ATTEMPTS.
  - 0: `err_pulse`, clear, go to ACC_ENTRY with count 0.
- PIN_ENTRY: the first valid digit is held as the PIN candidate; later digits are ignored. `enter` with no digit held is ignored.
- PIN_ENTRY `enter`: `pin` = candidate, `action` = AUTHENTICATE (same edge), go to AUTH_WAIT.
- AUTH_WAIT, one cycle, sample `wasSuccessful`:
  - 1: latch `session_index` = `accIndex`, set `session_active`, go to SESSION.
  - 0: `err_pulse`, decrement `attempts_left`. At 0 go to LOCKED; otherwise return to PIN_ENTRY with the candidate cleared.
- SESSION: `logout` or `cancel` → `deAuth` = 1 for one cycle, clear all registered outputs, go to IDLE. Digits and `enter` are ignored.
- LOCKED: `locked` = 1, all keys ignored. After LOCK_CYCLES cycles, go to IDLE and restore `attempts_left` = MAX_ATTEMPTS.
- `cancel` in ACC_ENTRY, FIND_WAIT, PIN_ENTRY or AUTH_WAIT → IDLE, outputs cleared, no `deAuth`.
- "Clear" means `accNumber` = 0, `pin` = 0, `action` = FIND.

## Timing
- All outputs are registered. Reset values:
  - `accNumber`, `pin`, `action`, `deAuth`, `session_active`, `session_index`, `locked`, `err_pulse`: 0.
  - `attempts_left`: MAX_ATTEMPTS.
  - state: IDLE.
- Result sampling: `enter` sampled at edge k updates `accNumber`/`pin`/`action` at edge k. Authentication settles within cycle k..k+1, and the result is sampled at edge k+1.
- Latencies: `err_pulse` or `session_active` is high from edge k+1, i.e. two edges after the enter strobe cycle begins. `deAuth` is high in the cycle after `logout` is sampled.
- `rst` has priority over every input, including mid-FIND_WAIT/AUTH_WAIT and mid-LOCKED. A reset does not pulse `deAuth`.
- LOCKED counter: counts 0..LOCK_CYCLES-1 and exits on the terminal count.

## Configuration
- `ATM_ENTRY_TIMEOUT_EN` defined:
  - An inactivity counter clears on every accepted key.
  - In ACC_ENTRY or PIN_ENTRY, reaching TIMEOUT_CYCLES → `err_pulse`, clear, IDLE.
  - In SESSION, reaching TIMEOUT_CYCLES → `deAuth` pulse, then IDLE.
- Not defined: no counter and no timeout; states wait indefinitely.

## Structure
- Shared package `atm_pkg` holds:
  - the state encoding;
  - the FIND/AUTHENTICATE constants;
  - the true/false constants;
  - the 4095 account-number limit.
- One sub-module: `atm_dec_accumulator`, which handles digit shift-multiply-add, count saturation, the overflow flag and clear.
- The FSM, attempt counter, lock counter and timeout counter live in the top.

## Test plan
- Digits 2,7,4,9, `enter` → `accNumber` = 2749, `action` = 0. Then digit 0, `enter` → `action` = 1, `session_active` = 1, `session_index` = 0.
- Account 2175 with PIN 5, three times → three `err_pulse`, `attempts_left` 3→2→1→0, `locked` = 1 for exactly 1000 cycles, then IDLE.
- Digits 9,9,9,9, `enter` → `err_pulse`, `accNumber` stays 0, FIND_WAIT never entered.
- Active session on 2910, `logout` → single-cycle `deAuth`, `session_active` = 0, `accNumber` = 0.
- `enter` and `digit_valid` asserted in the same cycle, and `cancel` during AUTH_WAIT → enter wins, cancel returns to IDLE. `rst` during FIND_WAIT → all outputs at reset values on the next edge.
- With `ATM_ENTRY_TIMEOUT_EN`: no keys for 5000 cycles in PIN_ENTRY → `err_pulse`, IDLE.
